r900_rs_encode: RTL and testbench

R900_RS_ENCODE -- requirements
Module: r900_rs_encode

---
 rtl/r900_rs_encode.sv | 151 +++++++++++++++
 tb/tb_r900_rs_encode.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r900_rs_encode.sv
// Shortened RS(31,26) GF(32) systematic encoder: 16 message symbols in, 21-symbol codeword out.
// Latency: pkt_vld on the 26th edge after acceptance; 28 cycles/codeword, 27 with R900_ENC_HOLD_BUF_EN.
// Backpressure: in_rdy in IDLE only (hold buffer empty with R900_ENC_HOLD_BUF_EN); refused inputs flagged on in_drop.
module r900_rs_encode (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_in,
    input  logic [79:0]  dta_in,
    output logic         in_rdy,
    output logic         in_drop,
    output logic         busy,
    output logic         pkt_vld,
    output logic [104:0] pkt_dta
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ZERO = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Multiply by alpha, reducing with x^5 = x^2 + 1.
    function automatic logic [4:0] mul_a(input logic [4:0] x);
        return {x[3], x[2], x[1] ^ x[4], x[0], x[4]};
    endfunction

    // g4 = g1 = a^13 = a^4 + a^3 + a^2
    function automatic logic [4:0] mul_g14(input logic [4:0] x);
        logic [4:0] x2;
        logic [4:0] x3;
        logic [4:0] x4;
        x2 = mul_a(mul_a(x));
        x3 = mul_a(x2);
        x4 = mul_a(x3);
        return x4 ^ x3 ^ x2;
    endfunction

    // g3 = g2 = a^17 = a^4 + a + 1
    function automatic logic [4:0] mul_g23(input logic [4:0] x);
        logic [4:0] x1;
        logic [4:0] x4;
        x1 = mul_a(x);
        x4 = mul_a(mul_a(mul_a(x1)));
        return x4 ^ x1 ^ x;
    endfunction

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [79:0] msg;
    logic [79:0] msg_sr;
    logic [24:0] lfsr;
    logic [24:0] lfsr_nxt;
    logic [4:0]  sym;
    logic [4:0]  fb;
    logic        accept;
    logic        start;
    logic [79:0] start_msg;

    assign accept = vld_in && in_rdy;
    assign busy   = (state != ST_IDLE);

`ifdef R900_ENC_HOLD_BUF_EN
    logic        hold_vld;
    logic [79:0] hold_dat;
    logic        start_hold;
    logic        hold_load;

    assign in_rdy     = ~hold_vld;
    assign start_hold = (state == ST_DONE) && hold_vld;
    // A message offered during DONE with an empty buffer starts directly.
    assign start      = start_hold || (accept && ((state == ST_IDLE) || (state == ST_DONE)));
    assign hold_load  = accept && ((state == ST_DATA) || (state == ST_ZERO));
    assign start_msg  = start_hold ? hold_dat : dta_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld <= 1'b0;
            hold_dat <= 80'd0;
        end else if (hold_load) begin
            hold_vld <= 1'b1;
            hold_dat <= dta_in;
        end else if (start_hold) begin
            hold_vld <= 1'b0;
        end
    end
`else
    assign in_rdy    = (state == ST_IDLE);
    assign start     = accept;
    assign start_msg = dta_in;
`endif

    // Premultiplied divider: after m then 10 zeros the register holds x^15*m(x) mod g(x).
    assign sym = (state == ST_DATA) ? msg_sr[79:75] : 5'd0;
    assign fb  = sym ^ lfsr[24:20];
    assign lfsr_nxt = {lfsr[19:15] ^ mul_g14(fb),
                       lfsr[14:10] ^ mul_g23(fb),
                       lfsr[9:5]   ^ mul_g23(fb),
                       lfsr[4:0]   ^ mul_g14(fb),
                       fb};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            msg     <= 80'd0;
            msg_sr  <= 80'd0;
            lfsr    <= 25'd0;
            pkt_vld <= 1'b0;
            pkt_dta <= 105'd0;
            in_drop <= 1'b0;
        end else begin
            pkt_vld <= 1'b0;
            in_drop <= vld_in && !in_rdy;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state  <= ST_DATA;
                        cnt    <= 4'd0;
                        lfsr   <= 25'd0;
                        msg    <= start_msg;
                        msg_sr <= start_msg;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    lfsr   <= lfsr_nxt;
                    msg_sr <= {msg_sr[74:0], 5'd0};
                    if (cnt == 4'd15) begin
                        state <= ST_ZERO;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_ZERO: begin
                    lfsr <= lfsr_nxt;
                    if (cnt == 4'd9) begin
                        state   <= ST_DONE;
                        cnt     <= 4'd0;
                        pkt_vld <= 1'b1;
                        pkt_dta <= {msg, lfsr_nxt};
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_r900_rs_encode.sv
// Bench for r900_rs_encode: random messages against a GF(32) long-division and syndrome reference.
module tb_r900_rs_encode;

    logic         clk = 1'b0;
    logic         rst;
    logic         vld_in;
    logic [79:0]  dta_in;
    logic         in_rdy;
    logic         in_drop;
    logic         busy;
    logic         pkt_vld;
    logic [104:0] pkt_dta;

    int checks = 0;
    int errors = 0;

    int gexp [0:30];
    int glog [0:31];
    int gen  [0:5];

    r900_rs_encode dut (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (vld_in),
        .dta_in  (dta_in),
        .in_rdy  (in_rdy),
        .in_drop (in_drop),
        .busy    (busy),
        .pkt_vld (pkt_vld),
        .pkt_dta (pkt_dta)
    );

    always #5 clk = ~clk;

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 31];
    endfunction

    task automatic build_field();
        int x;
        x = 1;
        for (int i = 0; i < 32; i++) glog[i] = 0;
        for (int i = 0; i < 31; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x << 1;
            if ((x & 32) != 0) x = x ^ 37;
        end
        for (int j = 0; j < 6; j++) gen[j] = 0;
        gen[0] = 1;
        for (int k = -2; k <= 2; k++) begin
            int r;
            r = gexp[(k + 31) % 31];
            for (int j = 5; j >= 1; j--) gen[j] = gen[j-1] ^ gmul(gen[j], r);
            gen[0] = gmul(gen[0], r);
        end
    endtask

    function automatic logic [24:0] model_parity(input logic [79:0] m);
        int c [0:30];
        int q;
        logic [24:0] p;
        for (int i = 0; i < 31; i++) c[i] = 0;
        for (int i = 0; i < 16; i++) c[15+i] = int'(m[5*i +: 5]);
        for (int pos = 30; pos >= 5; pos--) begin
            q = c[pos];
            if (q != 0)
                for (int j = 0; j <= 5; j++) c[pos-5+j] = c[pos-5+j] ^ gmul(q, gen[j]);
        end
        for (int j = 0; j < 5; j++) p[5*j +: 5] = 5'(c[j]);
        return p;
    endfunction

    function automatic int pos_of(input int idx);
        return (idx < 5) ? idx : idx + 10;
    endfunction

    function automatic int syn(input logic [104:0] cw, input int k);
        int s;
        int e;
        s = 0;
        for (int idx = 0; idx < 21; idx++) begin
            e = ((k * pos_of(idx)) % 31 + 31) % 31;
            s = s ^ gmul(int'(cw[5*idx +: 5]), gexp[e]);
        end
        return s;
    endfunction

    function automatic bit syn_zero(input logic [104:0] cw);
        for (int k = -2; k <= 2; k++) if (syn(cw, k) != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Single-symbol-error decoder: S0 = e, S1 = e*a^pos.
    task automatic decode1(input logic [104:0] rx, output logic [104:0] corr, output bit flag);
        int s0;
        int s1;
        int pos;
        int idx;
        corr = rx;
        flag = 1'b0;
        if (syn_zero(rx)) return;
        s0 = syn(rx, 0);
        s1 = syn(rx, 1);
        if (s0 == 0 || s1 == 0) return;
        pos = (glog[s1] - glog[s0] + 31) % 31;
        if (pos < 5) idx = pos;
        else if (pos >= 15) idx = pos - 10;
        else return;
        corr[5*idx +: 5] = corr[5*idx +: 5] ^ 5'(s0);
        flag = syn_zero(corr);
    endtask

    function automatic logic [79:0] rand_msg();
        return {$urandom, $urandom, 16'($urandom)};
    endfunction

    task automatic encode_one(input logic [79:0] m, output logic [104:0] cw, output int lat);
        int w;
        lat = 0;
        w = 0;
        @(negedge clk);
        while (!in_rdy && w < 60) begin
            @(negedge clk);
            w++;
        end
        vld_in = 1'b1;
        dta_in = m;
        @(posedge clk);
        #1 vld_in = 1'b0;
        while (!pkt_vld && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        cw = pkt_dta;
    endtask

    task automatic do_reset();
        vld_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 vld_in = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (pkt_vld !== 1'b0 || busy !== 1'b0 || in_drop !== 1'b0 || pkt_dta !== 105'd0) begin
            errors++;
            $display("FAIL reset_state: vld=%b busy=%b drop=%b dta=%h, want 0 0 0 0", pkt_vld, busy, in_drop, pkt_dta);
        end
        vld_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_rdy !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_rdy=%b busy=%b, want 1 0", in_rdy, busy);
        end
    endtask

    task automatic test_zero_msg();
        logic [104:0] cw;
        int lat;
        encode_one(80'd0, cw, lat);
        checks++;
        if (lat != 26) begin
            errors++;
            $display("FAIL zero_latency: got %0d edges, want 26", lat);
        end
        checks++;
        if (cw !== 105'd0) begin
            errors++;
            $display("FAIL zero_codeword: got %h, want 0", cw);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pkt_vld !== 1'b0 || in_rdy !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_after_done: vld=%b rdy=%b busy=%b, want 0 1 0", pkt_vld, in_rdy, busy);
        end
    endtask

    task automatic test_one_msg();
        logic [104:0] cw;
        logic [104:0] exp_cw;
        int lat;
        exp_cw = {80'd1, model_parity(80'd1)};
        encode_one(80'd1, cw, lat);
        checks++;
        if (cw !== exp_cw || lat != 26) begin
            errors++;
            $display("FAIL one_codeword: got %h lat %0d, want %h lat 26", cw, lat, exp_cw);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL one_busy_done: got %b, want 1", busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pkt_vld !== 1'b0 || pkt_dta !== exp_cw) begin
            errors++;
            $display("FAIL one_hold: vld=%b dta=%h, want 0 %h", pkt_vld, pkt_dta, exp_cw);
        end
    endtask

    task automatic test_random(input int n);
        logic [79:0]  m;
        logic [104:0] cw;
        logic [104:0] exp_cw;
        int lat;
        for (int t = 0; t < n; t++) begin
            m = rand_msg();
            exp_cw = {m, model_parity(m)};
            encode_one(m, cw, lat);
            checks++;
            if (cw !== exp_cw || lat != 26) begin
                errors++;
                $display("FAIL rand_codeword[%0d]: got %h lat %0d, want %h lat 26", t, cw, lat, exp_cw);
            end
            checks++;
            if (!syn_zero(cw) || cw[104:25] !== m) begin
                errors++;
                $display("FAIL rand_syndrome[%0d]: got %h, want zero syndromes and msg %h", t, cw, m);
            end
        end
    endtask

    task automatic test_roundtrip(input int n);
        logic [79:0]  m;
        logic [104:0] cw;
        logic [104:0] bad;
        logic [104:0] corr;
        bit flag;
        int lat;
        int idx;
        int ev;
        for (int t = 0; t < n; t++) begin
            m = rand_msg();
            encode_one(m, cw, lat);
            idx = $urandom_range(0, 20);
            ev = $urandom_range(1, 31);
            bad = cw;
            bad[5*idx +: 5] = bad[5*idx +: 5] ^ 5'(ev);
            decode1(bad, corr, flag);
            checks++;
            if (corr !== cw || flag !== 1'b1 || cw[104:25] !== m) begin
                errors++;
                $display("FAIL roundtrip[%0d]: got %h flag %b, want %h flag 1", t, corr, flag, cw);
            end
        end
    endtask

`ifndef R900_ENC_HOLD_BUF_EN
    task automatic test_stream();
        logic [79:0]  q [$];
        logic [79:0]  m;
        logic [104:0] exp_cw;
        int acc [0:3];
        int acc_n;
        int drop_n;
        int vld_n;
        acc_n = 0;
        drop_n = 0;
        vld_n = 0;
        for (int i = 0; i < 4; i++) acc[i] = -1;
        do_reset();
        for (int c = 0; c < 100; c++) begin
            if (c < 60) begin
                @(negedge clk);
                vld_in = 1'b1;
                dta_in = rand_msg();
                if (in_rdy) begin
                    if (acc_n < 4) acc[acc_n] = c;
                    acc_n++;
                    q.push_back(dta_in);
                end
            end
            @(posedge clk);
            #1;
            if (c == 59) vld_in = 1'b0;
            if (in_drop) drop_n++;
            if (pkt_vld) begin
                vld_n++;
                m = (q.size() > 0) ? q.pop_front() : 80'd0;
                exp_cw = {m, model_parity(m)};
                checks++;
                if (pkt_dta !== exp_cw) begin
                    errors++;
                    $display("FAIL stream_codeword[%0d]: got %h, want %h", vld_n, pkt_dta, exp_cw);
                end
            end
        end
        checks++;
        if (acc_n != 3 || acc[0] != 0 || acc[1] != 28 || acc[2] != 56) begin
            errors++;
            $display("FAIL stream_accepts: got n=%0d at %0d %0d %0d, want 3 at 0 28 56", acc_n, acc[0], acc[1], acc[2]);
        end
        checks++;
        if (drop_n != 57) begin
            errors++;
            $display("FAIL stream_drops: got %0d, want 57", drop_n);
        end
        checks++;
        if (vld_n != 3) begin
            errors++;
            $display("FAIL stream_pkts: got %0d, want 3", vld_n);
        end
    endtask
`else
    task automatic test_hold();
        logic [79:0]  m0;
        logic [79:0]  m1;
        logic [104:0] cw [0:1];
        int t_vld [0:1];
        int vld_n;
        int rdy_bad;
        m0 = rand_msg();
        m1 = rand_msg();
        vld_n = 0;
        rdy_bad = 0;
        t_vld[0] = -1;
        t_vld[1] = -1;
        do_reset();
        vld_in = 1'b1;
        dta_in = m0;
        @(posedge clk);
        #1 dta_in = m1;
        @(posedge clk);
        #1 vld_in = 1'b0;
        // Buffer is full from edge 1 until DONE consumes it on edge 27.
        for (int e = 1; e <= 60; e++) begin
            if (e > 1) begin
                @(posedge clk);
                #1;
            end
            if (in_rdy !== ((e >= 1 && e <= 26) ? 1'b0 : 1'b1)) rdy_bad++;
            if (pkt_vld) begin
                if (vld_n < 2) begin
                    t_vld[vld_n] = e;
                    cw[vld_n] = pkt_dta;
                end
                vld_n++;
            end
        end
        checks++;
        if (vld_n != 2 || t_vld[0] != 26 || t_vld[1] != 53) begin
            errors++;
            $display("FAIL hold_timing: got n=%0d at %0d %0d, want 2 at 26 53", vld_n, t_vld[0], t_vld[1]);
        end
        checks++;
        if (cw[0] !== {m0, model_parity(m0)} || cw[1] !== {m1, model_parity(m1)}) begin
            errors++;
            $display("FAIL hold_codewords: got %h %h", cw[0], cw[1]);
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++;
            $display("FAIL hold_in_rdy: got %0d wrong cycles, want 0", rdy_bad);
        end
    endtask
`endif

    task automatic test_reset_abort();
        logic [79:0]  m;
        logic [104:0] cw;
        int lat;
        int seen;
        @(negedge clk);
        while (!in_rdy) @(negedge clk);
        vld_in = 1'b1;
        dta_in = rand_msg();
        @(posedge clk);
        #1 vld_in = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (pkt_vld !== 1'b0 || busy !== 1'b0 || pkt_dta !== 105'd0 || in_drop !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: vld=%b busy=%b dta=%h drop=%b, want all 0", pkt_vld, busy, pkt_dta, in_drop);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_rdy: got %b, want 1", in_rdy);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (pkt_vld) seen++;
        end
        checks++;
        if (seen != 0 || pkt_dta !== 105'd0) begin
            errors++;
            $display("FAIL abort_no_pkt: got %0d pulses dta %h, want 0 and 0", seen, pkt_dta);
        end
        m = rand_msg();
        encode_one(m, cw, lat);
        checks++;
        if (cw !== {m, model_parity(m)} || lat != 26) begin
            errors++;
            $display("FAIL abort_next: got %h lat %0d, want %h lat 26", cw, lat, {m, model_parity(m)});
        end
    endtask

    initial begin
        rst = 1'b1;
        vld_in = 1'b0;
        dta_in = 80'd0;
        build_field();
        test_reset();
        test_zero_msg();
        test_one_msg();
        test_random(1000);
        test_roundtrip(20);
`ifndef R900_ENC_HOLD_BUF_EN
        test_stream();
`else
        test_hold();
`endif
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
